usb_packet_rx: RTL and testbench
================================

Name: usb_packet_rx

Overview:
- Parametrised USB full-speed receive engine; successor to the fixed-width receiver top level.
- Contains internally: synchroniser, edge-resynced bit timer, NRZI decode, bit unstuffing, SYNC/PID checking and a packet framer.
- Emits tagged bytes into one internal FIFO with a valid/ready output, so per-type FIFOs are not needed.
- Sits between the D+/D- pads and the AES packet handler.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit time; must be ≥4.
FIFO_DEPTH, 8, output FIFO entries; must be ≥2.
SYNC_STAGES, 2, flip-flop stages on d_plus and d_minus.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
d_plus  in  1  raw D+ line
d_minus  in  1  raw D- line
out_ready  in  1  consumer accepts the head entry
out_valid  out  1  FIFO non-empty
out_data  out  8  head byte
out_tag  out  2  0=PID, 1=DATA, 2=CRC, 3=NONDATA
out_last  out  1  head byte is the final byte of its packet
fifo_count  out  $clog2(FIFO_DEPTH+1)  number of entries held
rcving  out  1  packet in progress (SYNC start to J after EOP)
r_error  out  1  sticky error; cleared on next SYNC start
overflow  out  1  sticky; set on write while full; cleared only by rst
crc_error  out  1  sticky CRC16 failure; cleared on next SYNC start

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE. Synchroniser stages reset to J (d_plus=1, d_minus=0). Previous-NRZI bit resets to 1.
- Bit timer:
  - Counter loads 0 on any synced d_plus transition; otherwise it increments modulo CLKS_PER_BIT.
  - A sample strobe fires when the counter equals CLKS_PER_BIT/2.
- Bit decode:
  - Decoded bit = 1 if the sampled d_plus equals the previous sample, else 0.
  - SE0 (both lines 0) at a strobe = EOP bit; it is not decoded.
  - Bytes are assembled LSB-first.
- Unstuffing:
  - After six consecutive decoded 1s, the next bit is discarded if it is 0.
  - If that bit is 1 → ERROR.
  - The ones-run counter resets on any 0 and at packet start.
- FSM states:
  - IDLE: on synced d_plus falling to K → SYNC; rcving=1; r_error and crc_error cleared.
  - SYNC: the first 8 decoded bits must equal 8'h80 → PID; anything else → ERROR.
  - PID: 8 bits assembled; requires pid[3:0]==~pid[7:4], else ERROR. Byte enters the hold pipeline. is_data = (pid[1:0]==2'b11). → BODY.
  - BODY: each completed byte enters the hold pipeline. SE0 at a strobe with bit count mod 8 == 0 → EOP. SE0 with a partial byte → ERROR.
  - EOP: flush the hold pipeline. On the first J strobe → IDLE; rcving=0 on the cycle after that strobe.
  - ERROR: r_error=1; hold pipeline discarded, no further writes. Wait for SE0, then J → IDLE.
- Hold pipeline (2 bytes deep):
  - Tagging of the final two bytes is decided at EOP.
  - A 3rd byte entering pushes the oldest held byte to the FIFO: PID tag if it was the PID byte, else DATA if is_data, else NONDATA.
  - At EOP, remaining held bytes are written one per cycle, oldest first. Tag: PID for the PID byte; CRC if is_data; NONDATA otherwise. out_last=1 on the final one.
  - A PID-only packet yields a single entry {PID, pid, last=1}.
- FIFO:
  - Write when the framer pushes; read when out_valid && out_ready.
  - Simultaneous read and write when full: both occur, no overflow.
  - Write when full without a read: entry dropped; overflow=1 and r_error=1.
  - Count never wraps.
- rst mid-packet: FSM to IDLE, FIFO emptied, all flags 0, within the reset assertion.
- Error during a packet: entries already written remain in the FIFO. No partial final entry is ever written.

Optional Feature:
- Macro: USB_RX_CRC16_CHECK_EN.
- Defined:
  - A CRC16 (poly 0x8005, init 0xFFFF, LSB-first) runs over every unstuffed bit after the PID of a data packet.
  - At EOP the register must equal residual 16'h800D. Otherwise crc_error=1 and r_error=1, asserted on the cycle EOP is detected.
  - Bytes are still flushed.
- Undefined: no CRC logic; crc_error tied to 0.

Test Plan:
- ACK: SYNC + PID 0xD2 + EOP → exactly one entry {tag=0, 0xD2, last=1}. rcving drops after J. r_error=0.
- DATA0: PID 0xC3, payload 0x01 0x02, bench-model CRC16 → entries PID 0xC3, DATA 0x01, DATA 0x02, CRC lo, CRC hi (last=1). crc_error=0 (macro on). Flipping one CRC bit → crc_error=1.
- Stuffing: DATA1 (0x4B) with payload 0xFF 0xFF correctly stuffed → both 0xFF received. Same packet with the stuffed 0 forced to 1 → r_error=1; no CRC entries written.
- Bad PID 0xD3, and SYNC 0x81 → r_error=1, FIFO empty. The next valid ACK clears r_error and is received.
- FIFO_DEPTH=4, out_ready=0, DATA0 with 4-byte payload → fifo_count=4, overflow=1. Driving out_ready=1 then drains 4 entries, the first being PID 0xC3.
- Assert rst mid-BODY with 3 entries queued → out_valid=0, fifo_count=0, rcving=0. The next packet is received normally.

Source files
------------

// File: rtl/usb_packet_rx.sv
// usb_packet_rx: USB full-speed receiver. Pads pass through a synchroniser, bit timer, NRZI decode,
//   unstuffing and SYNC/PID check, then a framer writes tagged bytes into one output FIFO.
// Latency: a byte is written two bytes after it completes on the wire; the last two are written at EOP, one per cycle.
// Backpressure: out_valid/out_ready on the FIFO head. A write to a full FIFO with no read drops the entry and sets overflow.
// Optional: define USB_RX_CRC16_CHECK_EN to check the CRC16 residual of data packets; otherwise crc_error is tied to 0.

module usb_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_wr, do_rd;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign do_rd  = rd_en && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_wr  = wr_en && (!full || do_rd);
  assign rd_dat = mem[rptr];

  // Storage array, written without reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_dat;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (do_rd) rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module usb_packet_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            d_plus,
  input  logic                            d_minus,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [7:0]                      out_data,
  output logic [1:0]                      out_tag,
  output logic                            out_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            rcving,
  output logic                            r_error,
  output logic                            overflow,
  output logic                            crc_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT-1);

  localparam logic [2:0] S_IDLE = 3'd0, S_SYNC = 3'd1, S_PID = 3'd2,
                         S_BODY = 3'd3, S_EOP  = 3'd4, S_ERR = 3'd5;
  localparam logic [1:0] TAG_PID = 2'd0, TAG_DATA = 2'd1, TAG_CRC = 2'd2, TAG_NONDATA = 2'd3;

  typedef struct packed {
    logic [1:0] tag;
    logic       last;
    logic [7:0] data;
  } rx_entry_t;

  logic [SYNC_STAGES-1:0] dp_sync, dm_sync;
  logic                   dp_s, dm_s, dp_prev;
  logic [CW-1:0]          cnt;
  logic                   strobe, se0, dbit, bit_ok, byte_done, sync_start, eop_det, crc_bad;
  logic [2:0]             state, bit_cnt, ones_cnt;
  logic [7:0]             sr, new_byte, h0, h1;
  logic                   h0_pid, h1_pid, is_data, prev_nrzi, seen_se0;
  logic [1:0]             hcnt;
  logic                   wr_en, rd_en, fifo_full, fifo_empty, ovf_set;
  rx_entry_t              wr_ent, rd_ent;

  assign dp_s = dp_sync[SYNC_STAGES-1];
  assign dm_s = dm_sync[SYNC_STAGES-1];

  // Pad synchroniser; stages idle at J so reset looks like a quiet bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_sync <= '1;
      dm_sync <= '0;
    end else begin
      dp_sync <= (dp_sync << 1) | SYNC_STAGES'(d_plus);
      dm_sync <= (dm_sync << 1) | SYNC_STAGES'(d_minus);
    end
  end

  // Bit timer realigns on every D+ edge so the strobe lands mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_prev <= 1'b1;
      cnt     <= '0;
    end else begin
      dp_prev <= dp_s;
      if (dp_s != dp_prev)  cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
    end
  end

  assign strobe     = (cnt == HALF);
  assign se0        = !dp_s && !dm_s;
  assign dbit       = (dp_s == prev_nrzi);
  assign new_byte   = {dbit, sr[7:1]};
  assign bit_ok     = strobe && !se0 && (ones_cnt != 3'd6) &&
                      (state == S_SYNC || state == S_PID || state == S_BODY);
  assign byte_done  = bit_ok && (bit_cnt == 3'd7);
  assign sync_start = (state == S_IDLE) && dp_prev && !dp_s && dm_s;
  assign eop_det    = strobe && se0 && (state == S_BODY) && (bit_cnt == 3'd0);

  // Framer output: oldest held byte leaves when a third arrives, or during the EOP flush.
  always_comb begin
    wr_en        = 1'b0;
    wr_ent.tag   = TAG_PID;
    wr_ent.last  = 1'b0;
    wr_ent.data  = h0;
    if (state == S_BODY && byte_done && hcnt == 2'd2) begin
      wr_en      = 1'b1;
      wr_ent.tag = h0_pid ? TAG_PID : (is_data ? TAG_DATA : TAG_NONDATA);
    end else if (state == S_EOP && hcnt != 2'd0) begin
      wr_en       = 1'b1;
      wr_ent.tag  = h0_pid ? TAG_PID : (is_data ? TAG_CRC : TAG_NONDATA);
      wr_ent.last = (hcnt == 2'd1);
    end
  end

  assign rd_en   = out_valid && out_ready;
  assign ovf_set = wr_en && fifo_full && !rd_en;

  // Packet FSM: decode, unstuff, frame, hold pipeline and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;   bit_cnt <= '0;  ones_cnt <= '0;  sr <= '0;
      prev_nrzi <= 1'b1; is_data <= 1'b0; seen_se0 <= 1'b0;
      h0 <= '0; h1 <= '0; h0_pid <= 1'b0; h1_pid <= 1'b0; hcnt <= '0;
      rcving <= 1'b0;    r_error <= 1'b0; overflow <= 1'b0;
    end else begin
      if (sync_start) begin
        state <= S_SYNC;   rcving <= 1'b1;  r_error <= 1'b0;
        bit_cnt <= '0;     ones_cnt <= '0;  prev_nrzi <= 1'b1;
        hcnt <= '0;        is_data <= 1'b0; seen_se0 <= 1'b0;
      end else if (strobe) begin
        case (state)
          S_SYNC, S_PID, S_BODY: begin
            if (se0) begin
              if (state == S_BODY && bit_cnt == 3'd0) state <= S_EOP;
              else begin state <= S_ERR; seen_se0 <= 1'b1; hcnt <= '0; end
            end else begin
              prev_nrzi <= dp_s;
              if (ones_cnt == 3'd6) begin
                // Stuffed bit: a 0 is dropped, a 1 is a protocol violation.
                if (dbit) begin state <= S_ERR; seen_se0 <= 1'b0; hcnt <= '0; end
                else ones_cnt <= '0;
              end else begin
                ones_cnt <= dbit ? ones_cnt + 3'd1 : 3'd0;
                sr       <= new_byte;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  case (state)
                    S_SYNC: state <= (new_byte == 8'h80) ? S_PID : S_ERR;
                    S_PID: begin
                      if (new_byte[3:0] == ~new_byte[7:4]) begin
                        state <= S_BODY; is_data <= (new_byte[1:0] == 2'b11);
                        h0 <= new_byte;  h0_pid <= 1'b1; hcnt <= 2'd1;
                      end else state <= S_ERR;
                    end
                    default: begin
                      if (hcnt == 2'd0)      begin h0 <= new_byte; h0_pid <= 1'b0; hcnt <= 2'd1; end
                      else if (hcnt == 2'd1) begin h1 <= new_byte; h1_pid <= 1'b0; hcnt <= 2'd2; end
                      else begin h0 <= h1; h0_pid <= h1_pid; h1 <= new_byte; h1_pid <= 1'b0; end
                    end
                  endcase
                end
              end
            end
          end
          S_EOP: if (!se0 && hcnt == 2'd0) begin state <= S_IDLE; rcving <= 1'b0; end
          S_ERR: begin
            if (se0) seen_se0 <= 1'b1;
            else if (seen_se0) begin state <= S_IDLE; rcving <= 1'b0; end
          end
          default: ;
        endcase
      end
      if (state == S_EOP && hcnt != 2'd0) begin
        h0 <= h1; h0_pid <= h1_pid; hcnt <= hcnt - 2'd1;
      end
      if (ovf_set) overflow <= 1'b1;
      if (ovf_set || crc_bad || state == S_ERR) r_error <= 1'b1;
    end
  end

`ifdef USB_RX_CRC16_CHECK_EN
  logic [15:0] crc;
  logic        crc_fb;
  assign crc_fb  = dbit ^ crc[15];
  assign crc_bad = eop_det && is_data && (crc != 16'h800D);

  // CRC16 over unstuffed body bits of data packets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             crc <= 16'hFFFF;
    else if (sync_start) crc <= 16'hFFFF;
    else if (bit_ok && state == S_BODY && is_data)
      crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
  end

  // Sticky CRC failure, cleared when the next packet starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             crc_error <= 1'b0;
    else if (sync_start) crc_error <= 1'b0;
    else if (crc_bad)    crc_error <= 1'b1;
  end
`else
  assign crc_bad   = 1'b0;
  assign crc_error = 1'b0;
`endif

  usb_rx_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_dat (wr_ent),
    .rd_en  (rd_en),
    .rd_dat (rd_ent),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? rd_ent.data : 8'h00;
  assign out_tag   = out_valid ? rd_ent.tag  : 2'd0;
  assign out_last  = out_valid && rd_ent.last;
endmodule

// File: tb/tb_usb_packet_rx.sv
// tb_usb_packet_rx: directed packets through usb_packet_rx with a scoreboard of expected FIFO entries.
// Latency: entries are compared whenever the DUT hands one over (out_valid && out_ready).
// Backpressure: out_ready is held low for the overflow and mid-packet reset cases.
`timescale 1ns/1ps
module tb_usb_packet_rx;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef USB_RX_CRC16_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, d_plus = 1'b1, d_minus = 1'b0, out_ready = 1'b0;
  logic       out_valid, out_last, rcving, r_error, overflow, crc_error;
  logic [7:0] out_data;
  logic [1:0] out_tag;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];   // {tag, last, data}
  logic [7:0]  tx_q[$];    // PID followed by body bytes
  logic [10:0] mon_exp;

  usb_packet_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .d_plus(d_plus), .d_minus(d_minus), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_last(out_last),
    .fifo_count(fifo_count), .rcving(rcving), .r_error(r_error), .overflow(overflow),
    .crc_error(crc_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each entry the consumer takes against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_entry", {31'd0, out_valid}, 32'd0);
      else begin
        mon_exp = exp_q.pop_front();
        check("entry", {21'd0, out_tag, out_last, out_data}, {21'd0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic dp, input logic dm);
    d_plus  = dp;
    d_minus = dm;
    repeat (CPB) tick();
  endtask

  // Append the USB CRC16 of tx_q[1..] (complemented, high-order bit sent first).
  task automatic append_crc(input bit flip);
    logic [15:0] c, t;
    logic [7:0]  lo, hi, b;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 1; k < tx_q.size(); k++) begin
      b = tx_q[k];
      for (int i = 0; i < 8; i++) begin
        fb = b[i] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    t = ~c;
    for (int i = 0; i < 8; i++) begin
      lo[i] = t[15-i];
      hi[i] = t[7-i];
    end
    if (flip) lo[3] = ~lo[3];
    tx_q.push_back(lo);
    tx_q.push_back(hi);
  endtask

  // Expected FIFO entries for tx_q, keeping only the first n_keep.
  task automatic expect_entries(input int n_keep);
    int         n;
    bit         data;
    logic [1:0] tg;
    n    = tx_q.size();
    data = (tx_q[0][1:0] == 2'b11);
    for (int i = 0; i < n && i < n_keep; i++) begin
      if (i == 0)          tg = 2'd0;
      else if (i >= n - 2) tg = data ? 2'd2 : 2'd3;
      else                 tg = data ? 2'd1 : 2'd3;
      exp_q.push_back({tg, (i == n - 1), tx_q[i]});
    end
  endtask

  // Serialise SYNC + tx_q with bit stuffing and NRZI; optional corrupt first stuff bit and EOP.
  task automatic send_packet(input logic [7:0] sync_b, input bit corrupt, input bit eop);
    bit         bits[$];
    logic       lvl;
    int         ones;
    bit         first;
    logic [7:0] b;
    b = sync_b;
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    for (int k = 0; k < tx_q.size(); k++) begin
      b = tx_q[k];
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    end
    lvl = 1'b1; ones = 0; first = 1'b1;
    for (int k = 0; k < bits.size(); k++) begin
      if (!bits[k]) lvl = ~lvl;
      drive_bit(lvl, ~lvl);
      ones = bits[k] ? ones + 1 : 0;
      if (ones == 6) begin
        if (!(corrupt && first)) lvl = ~lvl;
        first = 1'b0;
        drive_bit(lvl, ~lvl);
        ones = 0;
      end
    end
    if (eop) begin
      check("rcving_mid", {31'd0, rcving}, 32'd1);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b0, 1'b0);
      repeat (3) drive_bit(1'b1, 1'b0);
      check("rcving_end", {31'd0, rcving}, 32'd0);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    repeat (4) tick();
    check(tag, exp_q.size(), 32'd0);
    check({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_flags", {28'd0, rcving, r_error, overflow, crc_error}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();

    // ACK: single PID entry
    tx_q = {8'hD2};
    expect_entries(99);
    send_packet(8'h80, 1'b0, 1'b1);
    drain("ack");
    check("ack_rerr", {31'd0, r_error}, 32'd0);

    // DATA0 with good CRC
    tx_q = {8'hC3, 8'h01, 8'h02};
    append_crc(1'b0);
    expect_entries(99);
    send_packet(8'h80, 1'b0, 1'b1);
    drain("data0");
    check("data0_crcerr", {31'd0, crc_error}, 32'd0);
    check("data0_rerr", {31'd0, r_error}, 32'd0);

    // DATA0 with one CRC bit flipped: bytes still flushed
    tx_q = {8'hC3, 8'h01, 8'h02};
    append_crc(1'b1);
    expect_entries(99);
    send_packet(8'h80, 1'b0, 1'b1);
    drain("badcrc");
    check("badcrc_crcerr", {31'd0, crc_error}, {31'd0, CRC_ON});
    check("badcrc_rerr", {31'd0, r_error}, {31'd0, CRC_ON});

    // DATA1 with stuffed 0xFF payload
    tx_q = {8'h4B, 8'hFF, 8'hFF};
    append_crc(1'b0);
    expect_entries(99);
    send_packet(8'h80, 1'b0, 1'b1);
    drain("stuff");
    check("stuff_rerr", {31'd0, r_error}, 32'd0);
    check("stuff_crcerr", {31'd0, crc_error}, 32'd0);

    // Same packet with the first stuffed bit forced to 1: nothing written
    send_packet(8'h80, 1'b1, 1'b1);
    drain("stufferr");
    check("stufferr_rerr", {31'd0, r_error}, 32'd1);

    // Bad PID check nibble
    tx_q = {8'hD3};
    send_packet(8'h80, 1'b0, 1'b1);
    drain("badpid");
    check("badpid_rerr", {31'd0, r_error}, 32'd1);

    // Bad SYNC pattern
    tx_q = {8'hD2};
    send_packet(8'h81, 1'b0, 1'b1);
    drain("badsync");
    check("badsync_rerr", {31'd0, r_error}, 32'd1);

    // A following valid ACK clears r_error and is received
    tx_q = {8'hD2};
    expect_entries(99);
    send_packet(8'h80, 1'b0, 1'b1);
    drain("recover");
    check("recover_rerr", {31'd0, r_error}, 32'd0);

    // Overflow: consumer stalled, 7 writes into a 4-entry FIFO
    out_ready = 1'b0;
    tx_q = {8'hC3, 8'h10, 8'h20, 8'h30, 8'h40};
    append_crc(1'b0);
    expect_entries(DEPTH);
    send_packet(8'h80, 1'b0, 1'b1);
    repeat (4) tick();
    check("ovf_count", {29'd0, fifo_count}, DEPTH);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_rerr", {31'd0, r_error}, 32'd1);
    check("ovf_head_pid", {22'd0, out_tag, out_data}, {22'd0, 2'd0, 8'hC3});
    out_ready = 1'b1;
    drain("ovf_drain");
    check("ovf_count_end", {29'd0, fifo_count}, 32'd0);

    // Reset mid-body with three entries queued
    out_ready = 1'b0;
    tx_q = {8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
    send_packet(8'h80, 1'b0, 1'b0);
    repeat (2) tick();
    check("mid_count", {29'd0, fifo_count}, 32'd3);
    check("mid_rcving", {31'd0, rcving}, 32'd1);
    rst = 1'b1;
    d_plus = 1'b1;
    d_minus = 1'b0;
    tick();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_count", {29'd0, fifo_count}, 32'd0);
    check("midrst_flags", {28'd0, rcving, r_error, overflow, crc_error}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;

    // Normal packet after reset
    tx_q = {8'hC3, 8'hA5};
    append_crc(1'b0);
    expect_entries(99);
    send_packet(8'h80, 1'b0, 1'b1);
    drain("post_rst");
    check("post_rst_rerr", {31'd0, r_error}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
